// File: rtl/data_memory_ctrl.sv
// Byte-addressable 32-bit data memory with a valid/ready request/response handshake and one-cycle load latency.
// Optional per-byte even parity with error injection is enabled by defining MEM_PARITY_EN.
module data_memory_ctrl #(
    parameter int ADDR_W    = 10,
    parameter bit INIT_ZERO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
`ifdef MEM_PARITY_EN
    input  logic              par_inject,
    output logic              rsp_perr,
`endif
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int DEPTH = 1 << (ADDR_W - 2);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RESP = 1'b1;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [0:0]  state;
    logic [31:0] mem [DEPTH] = '{default: (INIT_ZERO ? 32'h0000_0000 : {32{1'bx}})};

    logic              accept;
    logic [ADDR_W-3:0] word_idx;
    logic [1:0]        lane_off;
    logic              misalign;
    logic [3:0]        lane_en;
    logic [31:0]       wdata_lanes;
    logic [31:0]       rd_word;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_data;

    assign req_ready = (state == IDLE) ? 1'b1 : rsp_ready;
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid & req_ready;
    assign word_idx  = req_addr[ADDR_W-1:2];
    assign lane_off  = req_addr[1:0];
    assign rd_word   = mem[word_idx];
    assign rd_byte   = rd_word[{lane_off, 3'b000} +: 8];
    assign rd_half   = lane_off[1] ? rd_word[31:16] : rd_word[15:0];

    // Decode size and offset into an error flag, the touched byte lanes and
    // the store data replicated so every candidate lane sees the right bytes.
    always_comb begin
        misalign    = 1'b0;
        lane_en     = 4'b0000;
        wdata_lanes = req_wdata;
        load_data   = 32'h0000_0000;
        case (req_size)
            SZ_BYTE: begin
                lane_en     = 4'b0001 << lane_off;
                wdata_lanes = {4{req_wdata[7:0]}};
                load_data   = {{24{~req_unsigned & rd_byte[7]}}, rd_byte};
            end
            SZ_HALF: begin
                misalign    = lane_off[0];
                lane_en     = lane_off[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{req_wdata[15:0]}};
                load_data   = {{16{~req_unsigned & rd_half[15]}}, rd_half};
            end
            SZ_WORD: begin
                misalign    = (lane_off != 2'b00);
                lane_en     = 4'b1111;
                wdata_lanes = req_wdata;
                load_data   = rd_word;
            end
            default: begin
                misalign = 1'b1;
            end
        endcase
    end

    // Storage has no reset so contents survive a controller reset.
    always_ff @(posedge clk) begin
        if (!rst && accept && req_we && !misalign) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[word_idx][i*8 +: 8] <= wdata_lanes[i*8 +: 8];
                end
            end
        end
    end

`ifdef MEM_PARITY_EN
    logic [3:0] par_mem [DEPTH] = '{default: (INIT_ZERO ? 4'h0 : {4{1'bx}})};
    logic [3:0] par_calc_wr;
    logic [3:0] par_calc_rd;
    logic       perr_now;

    always_comb begin
        par_calc_wr = 4'h0;
        par_calc_rd = 4'h0;
        for (int i = 0; i < 4; i++) begin
            par_calc_wr[i] = ^wdata_lanes[i*8 +: 8];
            par_calc_rd[i] = ^rd_word[i*8 +: 8];
        end
    end

    assign perr_now = |(lane_en & (par_mem[word_idx] ^ par_calc_rd));

    always_ff @(posedge clk) begin
        if (!rst && accept && req_we && !misalign) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    par_mem[word_idx][i] <= par_calc_wr[i] ^ par_inject;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_perr <= 1'b0;
        end else if (accept) begin
            rsp_perr <= !req_we && !misalign && perr_now;
        end
    end
`endif

    // Response registers load at acceptance and otherwise hold, so a stalled
    // response stays stable until the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rsp_rdata <= 32'h0000_0000;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            state     <= RESP;
            rsp_err   <= misalign;
            rsp_rdata <= (misalign || req_we) ? 32'h0000_0000 : load_data;
        end else if (state == RESP && rsp_ready) begin
            state <= IDLE;
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: a driver pushes expected responses, a negedge monitor pops and compares.
// Parity scenarios are included when MEM_PARITY_EN is defined.
module tb_data_memory_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [9:0]  req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        par_inject;
`ifdef MEM_PARITY_EN
    logic        rsp_perr;
`endif

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        perr;
    } exp_t;

    exp_t sb[$];
    int   chk_count  = 0;
    int   pass_count = 0;
    int   waited;

    data_memory_ctrl #(.ADDR_W(10), .INIT_ZERO(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef MEM_PARITY_EN
        .par_inject   (par_inject),
        .rsp_perr     (rsp_perr),
`endif
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        chk_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: a response is consumed at the next posedge when valid and ready are both high here.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk_count++;
                $display("[TB] FAIL unexpected_rsp: got rdata 0x%08h err %0b, expected no response", rsp_rdata, rsp_err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("rsp_rdata", rsp_rdata, e.rdata);
                checkOutput("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
`ifdef MEM_PARITY_EN
                checkOutput("rsp_perr", {31'b0, rsp_perr}, {31'b0, e.perr});
`endif
            end
        end
    end

    // Drives one request from posedge+1 until accepted; returns at posedge+1 after acceptance.
    task automatic applyStimulus(input logic we, input logic [9:0] addr, input logic [1:0] size,
                                 input logic uns, input logic [31:0] wdata, input logic inj,
                                 input logic [31:0] exp_rdata, input logic exp_err, input logic exp_perr,
                                 input bit push, output int wait_cycles);
        exp_t e;
        bit   ok = 1'b0;
        wait_cycles  = 0;
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        par_inject   = inj;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.perr  = exp_perr;
        if (push) sb.push_back(e);
        for (int w = 0; w < 50; w++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            wait_cycles++;
        end
        if (!ok) begin
            chk_count++;
            $display("[TB] FAIL accept_timeout: got req_ready 0 for 50 cycles, expected 1");
        end
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        par_inject = 1'b0;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int w = 0; w < 50; w++) begin
            @(negedge clk);
            if (!rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk_count++;
            $display("[TB] FAIL drain_timeout: got rsp_valid 1 for 50 cycles, expected 0");
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = '0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_wdata    = '0;
        rsp_ready    = 1'b1;
        par_inject   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("ready_after_reset", {31'b0, req_ready}, 32'd1);

        // Word store then signed byte load of the top lane
        applyStimulus(1, 10'h010, 2'b10, 0, 32'hDEADBEEF, 0, 32'h0, 0, 0, 1, waited);
        applyStimulus(0, 10'h013, 2'b00, 0, 32'h0, 0, 32'hFFFFFFDE, 0, 0, 1, waited);

        // Half store into the upper half of a known word
        applyStimulus(1, 10'h020, 2'b10, 0, 32'h11223344, 0, 32'h0, 0, 0, 1, waited);
        applyStimulus(1, 10'h022, 2'b01, 0, 32'h00008001, 0, 32'h0, 0, 0, 1, waited);
        applyStimulus(0, 10'h022, 2'b01, 1, 32'h0, 0, 32'h00008001, 0, 0, 1, waited);
        applyStimulus(0, 10'h022, 2'b01, 0, 32'h0, 0, 32'hFFFF8001, 0, 0, 1, waited);
        applyStimulus(0, 10'h020, 2'b10, 0, 32'h0, 0, 32'h80013344, 0, 0, 1, waited);

        // Alignment and illegal-size errors
        applyStimulus(1, 10'h004, 2'b10, 0, 32'hAAAA5555, 0, 32'h0, 0, 0, 1, waited);
        applyStimulus(1, 10'h006, 2'b10, 0, 32'h12345678, 0, 32'h0, 1, 0, 1, waited);
        applyStimulus(0, 10'h006, 2'b10, 0, 32'h0, 0, 32'h0, 1, 0, 1, waited);
        applyStimulus(0, 10'h004, 2'b10, 0, 32'h0, 0, 32'hAAAA5555, 0, 0, 1, waited);
        applyStimulus(1, 10'h021, 2'b01, 0, 32'h0000FFFF, 0, 32'h0, 1, 0, 1, waited);
        applyStimulus(0, 10'h008, 2'b11, 0, 32'h0, 0, 32'h0, 1, 0, 1, waited);
        applyStimulus(0, 10'h020, 2'b10, 0, 32'h0, 0, 32'h80013344, 0, 0, 1, waited);

        // Stall the consumer for three cycles, then four back-to-back loads
        drain();
        rsp_ready = 1'b0;
        applyStimulus(0, 10'h010, 2'b10, 0, 32'h0, 0, 32'hDEADBEEF, 0, 0, 1, waited);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("stall_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            checkOutput("stall_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
            checkOutput("stall_req_ready", {31'b0, req_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        applyStimulus(0, 10'h010, 2'b10, 0, 32'h0, 0, 32'hDEADBEEF, 0, 0, 1, waited);
        checkOutput("b2b_wait0", waited, 32'd0);
        applyStimulus(0, 10'h022, 2'b01, 1, 32'h0, 0, 32'h00008001, 0, 0, 1, waited);
        checkOutput("b2b_wait1", waited, 32'd0);
        applyStimulus(0, 10'h013, 2'b00, 1, 32'h0, 0, 32'h000000DE, 0, 0, 1, waited);
        checkOutput("b2b_wait2", waited, 32'd0);
        applyStimulus(0, 10'h020, 2'b10, 0, 32'h0, 0, 32'h80013344, 0, 0, 1, waited);
        checkOutput("b2b_wait3", waited, 32'd0);

        // Reset while a response is pending discards it but keeps memory
        drain();
        applyStimulus(1, 10'h040, 2'b10, 0, 32'hCAFEF00D, 0, 32'h0, 0, 0, 1, waited);
        drain();
        rsp_ready = 1'b0;
        applyStimulus(0, 10'h040, 2'b10, 0, 32'h0, 0, 32'h0, 0, 0, 0, waited);
        checkOutput("pending_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_in_resp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("rst_in_resp_rdata", rsp_rdata, 32'd0);
        rst       = 1'b0;
        rsp_ready = 1'b1;
        #1;
        checkOutput("ready_after_rst2", {31'b0, req_ready}, 32'd1);
        applyStimulus(0, 10'h040, 2'b10, 0, 32'h0, 0, 32'hCAFEF00D, 0, 0, 1, waited);

`ifdef MEM_PARITY_EN
        // Corrupted parity on one byte lane is reported only for that lane
        applyStimulus(1, 10'h030, 2'b10, 0, 32'h00000000, 0, 32'h0, 0, 0, 1, waited);
        applyStimulus(1, 10'h031, 2'b00, 0, 32'h0000005A, 1, 32'h0, 0, 0, 1, waited);
        applyStimulus(0, 10'h031, 2'b00, 1, 32'h0, 0, 32'h0000005A, 0, 1, 1, waited);
        applyStimulus(0, 10'h030, 2'b00, 1, 32'h0, 0, 32'h00000000, 0, 0, 1, waited);
`endif

        drain();
        checkOutput("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_count, chk_count);
        $finish;
    end

endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10: byte-address width; storage SHALL be 2^(ADDR_W-2) words of 32 bits.
REQ-002 The block SHALL have parameter INIT_ZERO, default 0: when 1, all words SHALL be 0 at simulation/elaboration start; when 0, contents SHALL be undefined.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, 1 bit: request present.
REQ-006 The block SHALL have port req_ready, output, 1 bit: request can be accepted.
REQ-007 The block SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 The block SHALL have port req_addr, input, ADDR_W bits: byte address.
REQ-009 The block SHALL have port req_size, input, 2 bits: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-010 The block SHALL have port req_unsigned, input, 1 bit: load zero-extends when 1 and sign-extends when 0.
REQ-011 The block SHALL have port req_wdata, input, 32 bits: store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 The block SHALL have port rsp_valid, output, 1 bit: response present.
REQ-013 The block SHALL have port rsp_ready, input, 1 bit: response consumed.
REQ-014 The block SHALL have port rsp_rdata, output, 32 bits: extended load data, and 0 for stores and errors.
REQ-015 The block SHALL have port rsp_err, output, 1 bit: misaligned or illegal-size request.

Function
REQ-016 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1; the request inputs SHALL be sampled only at acceptance.
REQ-017 The FSM SHALL have states IDLE and RESP, with req_ready = 1 in IDLE, req_ready = rsp_ready in RESP, and rsp_valid = 1 only in RESP.
REQ-018 State transitions SHALL be: IDLE→RESP on accept; RESP→IDLE on rsp_ready with no accept; RESP→RESP on rsp_ready with an accept (back-to-back, one transaction per cycle).
REQ-019 Latency SHALL be fixed: an accept at edge N SHALL give rsp_valid = 1 from edge N with response data valid after edge N, i.e. exactly one cycle.
REQ-020 While rsp_valid = 1 and rsp_ready = 0, rsp_rdata and rsp_err SHALL hold stable and no request SHALL be accepted.
REQ-021 Alignment errors SHALL be: half with addr[0] = 1; word with addr[1:0] ≠ 00; any size 11; each SHALL give rsp_err = 1 and rsp_rdata = 0, with no memory write.
REQ-022 Word index SHALL be addr[ADDR_W-1:2] and lane offset SHALL be addr[1:0]; a store SHALL write only the addressed byte lanes (byte: 1 lane, half: lanes {addr[1],0..1}, word: all 4) at the accepting edge.
REQ-023 A load SHALL read the word at the accepting edge, select the addressed lanes, and extend to 32 bits per req_unsigned; req_unsigned SHALL be ignored for word loads.
REQ-024 A load accepted the cycle after a store to the same word SHALL return the updated data.
REQ-025 A store response SHALL have rsp_err = 0 (if aligned) and rsp_rdata = 0.

Reset
REQ-026 When rst = 1 at an edge: state SHALL become IDLE, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, and no request SHALL be accepted or written.
REQ-027 Reset SHALL NOT alter memory contents; a pending response SHALL be discarded.
REQ-028 req_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-029 Macro MEM_PARITY_EN: when defined, the block SHALL store one even-parity bit per byte, updated on the written lanes.
REQ-030 MEM_PARITY_EN: when defined, the block SHALL add input par_inject (1 bit), which inverts the stored parity of the written lanes for that store.
REQ-031 MEM_PARITY_EN: when defined, the block SHALL add output rsp_perr (1 bit, reset 0), set when any lane read by a load mismatches its parity; rsp_rdata SHALL still be returned.
REQ-032 When MEM_PARITY_EN is undefined, the block SHALL have no parity storage, no par_inject port and no rsp_perr port.

Verification
REQ-033 The bench SHALL cover: word store 0xDEADBEEF @0x10, then byte load signed @0x13 → rdata 0xFFFFFFDE, err 0.
REQ-034 The bench SHALL cover: half store 0x8001 @0x22, then half load unsigned @0x22 → 0x00008001; half load signed → 0xFFFF8001; word @0x20 lanes [15:0] unchanged.
REQ-035 The bench SHALL cover: word load @0x06 → err 1, rdata 0; a preceding word store @0x06 → err 1, memory @0x04 unchanged.
REQ-036 The bench SHALL cover: rsp_ready held 0 for 3 cycles after a load → rsp_valid, rsp_rdata stable, req_ready 0; then 4 back-to-back accepts with rsp_ready = 1 → 4 consecutive responses.
REQ-037 The bench SHALL cover: rst asserted in RESP → rsp_valid 0 next cycle; a load of the prior store address after reset returns the stored value.
REQ-038 The bench SHALL cover, with MEM_PARITY_EN: byte store with par_inject = 1 @0x31, then byte load @0x31 → rsp_perr 1; load @0x30 → rsp_perr 0.
